// File: rtl/divider_param.sv
// divider_param: sequential restoring divider, N-bit dividend by M-bit divisor,
// with optional truncating signed mode and divide-by-zero / overflow flags.
module divider_param #(
    parameter int N         = 8,
    parameter int M         = 7,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         signed_mode,
    input  logic [N-1:0] dividendin,
    input  logic [M-1:0] divisorin,
    output logic [N-1:0] quotient,
    output logic [M-1:0] remainder,
    output logic         valid,
    output logic         busy,
    output logic         div_by_zero,
    output logic         overflow,
    output logic         load_w,
    output logic         shift_w,
    output logic         inbit_w,
    output logic         sign_w
);
    localparam int           CW   = $clog2(N + 1);
    localparam logic [N-1:0] QMIN = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, LOAD, ITER, FIX, DONE} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  quo_q, quo_d;
    logic [M:0]    rem_q, rem_d;
    logic [M-1:0]  dvs_q;
    logic          qneg_q, rneg_q, dbz_int_q, ovf_int_q;

    logic [N-1:0]  quotient_q;
    logic [M-1:0]  remainder_q;
    logic          valid_q, busy_q, div_by_zero_q, overflow_q;

    logic          sgn, a_neg, b_neg, inbit;
    logic [N-1:0]  a_mag, q_fix;
    logic [M-1:0]  b_mag, r_fix;
    logic [M+1:0]  shifted, diff;

    always_comb begin
        sgn     = SIGNED_EN & signed_mode;
        a_neg   = sgn & dividendin[N-1];
        b_neg   = sgn & divisorin[M-1];
        a_mag   = a_neg ? -dividendin : dividendin;
        b_mag   = b_neg ? -divisorin : divisorin;
        // Partial remainder never exceeds M bits, so the top bit of diff is the borrow.
        shifted = {rem_q, quo_q[N-1]};
        diff    = shifted - {2'b00, dvs_q};
        inbit   = ~diff[M+1];
        rem_d   = inbit ? diff[M:0] : shifted[M:0];
        quo_d   = {quo_q[N-2:0], inbit};
        q_fix   = qneg_q ? -quo_q : quo_q;
        r_fix   = rneg_q ? -rem_q[M-1:0] : rem_q[M-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            quo_q         <= '0;
            rem_q         <= '0;
            dvs_q         <= '0;
            qneg_q        <= 1'b0;
            rneg_q        <= 1'b0;
            dbz_int_q     <= 1'b0;
            ovf_int_q     <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            valid_q       <= 1'b0;
            busy_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q       <= LOAD;
                        valid_q       <= 1'b0;
                        busy_q        <= 1'b1;
                        div_by_zero_q <= 1'b0;
                        overflow_q    <= 1'b0;
                    end
                end
                LOAD: begin
                    quo_q     <= a_mag;
                    rem_q     <= '0;
                    dvs_q     <= b_mag;
                    qneg_q    <= a_neg ^ b_neg;
                    rneg_q    <= a_neg;
                    dbz_int_q <= (divisorin == '0);
                    ovf_int_q <= sgn && (dividendin == QMIN) && (divisorin == '1);
                    cnt_q     <= CW'(N);
                    state_q   <= ITER;
                end
                ITER: begin
                    quo_q <= quo_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_q <= FIX;
                end
                FIX: begin
                    if (dbz_int_q) begin
                        quotient_q    <= '1;
                        remainder_q   <= '0;
                        div_by_zero_q <= 1'b1;
                        overflow_q    <= 1'b0;
                    end else if (ovf_int_q) begin
                        quotient_q    <= QMIN;
                        remainder_q   <= '0;
                        div_by_zero_q <= 1'b0;
                        overflow_q    <= 1'b1;
                    end else begin
                        quotient_q    <= q_fix;
                        remainder_q   <= r_fix;
                        div_by_zero_q <= 1'b0;
                        overflow_q    <= 1'b0;
                    end
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign valid       = valid_q;
    assign busy        = busy_q;
    assign div_by_zero = div_by_zero_q;
    assign overflow    = overflow_q;
    assign load_w      = (state_q == LOAD);
    assign shift_w     = (state_q == ITER);
    assign inbit_w     = (state_q == ITER) & inbit;
    assign sign_w      = (state_q == FIX) & ~dbz_int_q & ~ovf_int_q & (qneg_q | rneg_q);

endmodule

// File: tb/tb_divider_param.sv
// Scoreboard bench for divider_param: an 8/7 instance with directed vectors and
// a 16/12 instance with a directed vector plus random cases in both modes.
module tb_divider_param;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_mis = 0;

    logic       start1 = 0, sm1 = 0;
    logic [7:0] a1 = '0;
    logic [6:0] b1 = '0;
    logic [7:0] q1;
    logic [6:0] r1;
    logic       v1, busy1, dz1, ov1, ld1, sh1, ib1, sg1;

    logic        start2 = 0, sm2 = 0;
    logic [15:0] a2 = '0;
    logic [11:0] b2 = '0;
    logic [15:0] q2;
    logic [11:0] r2;
    logic        v2, busy2, dz2, ov2, ld2, sh2, ib2, sg2;

    divider_param #(.N(8), .M(7), .SIGNED_EN(1'b1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .signed_mode(sm1),
        .dividendin(a1), .divisorin(b1), .quotient(q1), .remainder(r1),
        .valid(v1), .busy(busy1), .div_by_zero(dz1), .overflow(ov1),
        .load_w(ld1), .shift_w(sh1), .inbit_w(ib1), .sign_w(sg1)
    );

    divider_param #(.N(16), .M(12), .SIGNED_EN(1'b1)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .signed_mode(sm2),
        .dividendin(a2), .divisorin(b2), .quotient(q2), .remainder(r2),
        .valid(v2), .busy(busy2), .div_by_zero(dz2), .overflow(ov2),
        .load_w(ld2), .shift_w(sh2), .inbit_w(ib2), .sign_w(sg2)
    );

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ov;
        int          e0;
    } exp_t;

    exp_t sb1[$];
    exp_t sb2[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Monitors: pop on each rising edge of valid.
    logic v1p = 1'b0;
    logic v2p = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (v1 && !v1p) begin
            if (sb1.size() == 0) begin
                n_vec++; n_mis++;
                $display("FAIL unexpected_valid1: got valid with empty scoreboard (cycle %0d)", cyc);
            end else begin
                e = sb1.pop_front();
                chk("q1", q1, e.q);
                chk("r1", r1, e.r);
                chk("dz1", dz1, e.dz);
                chk("ov1", ov1, e.ov);
                chk("latency1", cyc - e.e0, 10);
                chk("busy_at_valid1", busy1, 0);
            end
        end
        v1p <= v1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (v2 && !v2p) begin
            if (sb2.size() == 0) begin
                n_vec++; n_mis++;
                $display("FAIL unexpected_valid2: got valid with empty scoreboard (cycle %0d)", cyc);
            end else begin
                e = sb2.pop_front();
                chk("q2", q2, e.q);
                chk("r2", r2, e.r);
                chk("dz2", dz2, e.dz);
                chk("ov2", ov2, e.ov);
                chk("latency2", cyc - e.e0, 18);
            end
        end
        v2p <= v2;
    end

    // esg: expected sign_w pulse (0/1), 2 = not checked; rep re-pulses start at E4.
    task automatic issue1(input logic [7:0] a, input logic [6:0] b, input logic sm,
                          input logic [7:0] eq, input logic [6:0] er, input logic edz,
                          input logic eov, input int esg, input logic rep);
        exp_t e;
        logic busy_ok, sg_seen;
        int   nsh, nld;
        @(negedge clk);
        start1 = 1'b1;
        sm1 = sm;
        e.q = 32'(eq); e.r = 32'(er); e.dz = edz; e.ov = eov; e.e0 = cyc + 1;
        sb1.push_back(e);
        busy_ok = 1'b1; sg_seen = 1'b0; nsh = 0; nld = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            start1 = rep && (k == 3);
            if (k == 0) begin
                a1 = a; b1 = b; sm1 = sm;
            end
            if (busy1 !== (k < 10)) busy_ok = 1'b0;
            if (sg1) sg_seen = 1'b1;
            if (sh1) nsh++;
            if (ld1) nld++;
        end
        chk("busy_window1", busy_ok, 1);
        chk("shift_cycles1", nsh, 8);
        chk("load_cycles1", nld, 1);
        if (esg != 2) chk("sign_w1", sg_seen, esg[0]);
        if (sb1.size() != 0) begin
            chk("timeout1", 0, 1);
            void'(sb1.pop_front());
        end
    endtask

    task automatic issue2(input logic [15:0] a, input logic [11:0] b, input logic sm,
                          input logic [15:0] eq, input logic [11:0] er, input logic edz,
                          input logic eov);
        exp_t e;
        @(negedge clk);
        start2 = 1'b1;
        sm2 = sm;
        e.q = 32'(eq); e.r = 32'(er); e.dz = edz; e.ov = eov; e.e0 = cyc + 1;
        sb2.push_back(e);
        for (int k = 0; k < 21; k++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (k == 0) begin
                a2 = a; b2 = b; sm2 = sm;
            end
        end
        if (sb2.size() != 0) begin
            chk("timeout2", 0, 1);
            void'(sb2.pop_front());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_q1", q1, 0);
        chk("rst_r1", r1, 0);
        chk("rst_flags1", {v1, busy1, dz1, ov1, ld1, sh1, ib1, sg1}, 0);
        reset = 1'b1;

        issue1(8'd200, 7'd7, 1'b0, 8'd28, 7'd4, 1'b0, 1'b0, 0, 1'b0);
        repeat (4) @(negedge clk);
        chk("hold_valid1", v1, 1);
        chk("hold_q1", q1, 28);
        chk("hold_r1", r1, 4);

        issue1(8'h9C, 7'h07, 1'b1, 8'hF2, 7'h7E, 1'b0, 1'b0, 1, 1'b0);
        issue1(8'd100, 7'h79, 1'b1, 8'hF2, 7'h02, 1'b0, 1'b0, 1, 1'b0);
        issue1(8'h9C, 7'h79, 1'b1, 8'h0E, 7'h7E, 1'b0, 1'b0, 1, 1'b0);
        issue1(8'd100, 7'd7, 1'b1, 8'd14, 7'd2, 1'b0, 1'b0, 0, 1'b0);
        issue1(8'h80, 7'h7F, 1'b1, 8'h80, 7'h00, 1'b0, 1'b1, 2, 1'b0);
        issue1(8'd128, 7'd127, 1'b0, 8'd1, 7'd1, 1'b0, 1'b0, 0, 1'b0);
        issue1(8'd55, 7'd0, 1'b0, 8'hFF, 7'd0, 1'b1, 1'b0, 0, 1'b0);
        issue1(8'd9, 7'd3, 1'b0, 8'd3, 7'd0, 1'b0, 1'b0, 0, 1'b0);
        issue1(8'd255, 7'd1, 1'b0, 8'd255, 7'd0, 1'b0, 1'b0, 0, 1'b0);
        issue1(8'hFB, 7'd0, 1'b1, 8'hFF, 7'd0, 1'b1, 1'b0, 2, 1'b0);
        issue1(8'd200, 7'd7, 1'b0, 8'd28, 7'd4, 1'b0, 1'b0, 0, 1'b1);

        // Abort mid-operation with reset, then a fresh operation.
        @(negedge clk);
        start1 = 1'b1; sm1 = 1'b0;
        @(negedge clk);
        start1 = 1'b0; a1 = 8'd77; b1 = 7'd5;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_q1", q1, 0);
        chk("abort_r1", r1, 0);
        chk("abort_flags1", {v1, busy1, dz1, ov1, ld1, sh1, ib1, sg1}, 0);
        @(negedge clk);
        reset = 1'b1;
        issue1(8'd9, 7'd3, 1'b0, 8'd3, 7'd0, 1'b0, 1'b0, 0, 1'b0);

        issue2(16'd65535, 12'd4095, 1'b0, 16'd16, 12'd15, 1'b0, 1'b0);
        for (int i = 0; i < 200; i++) begin
            logic [15:0] a;
            logic [11:0] b;
            logic        sm;
            int          sa, sbv, qq, rr;
            a  = 16'($urandom);
            b  = 12'($urandom_range(1, 4095));
            sm = i[0];
            if (sm) begin
                sa  = $signed(a);
                sbv = $signed(b);
            end else begin
                sa  = int'(a);
                sbv = int'(b);
            end
            qq = sa / sbv;
            rr = sa % sbv;
            issue2(a, b, sm, qq[15:0], rr[11:0], 1'b0,
                   sm && (a == 16'h8000) && (b == 12'hFFF));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
